// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module : serial_pkg
// Brief  : Shared state encoding and default width for the bit-serial subtractor.
// Rev    : 1.0
// ============================================================================
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/sub_1bit.sv
`default_nettype none
// ============================================================================
// Module : sub_1bit
// Brief  : Combinational 1-bit full subtractor (a - b - bin).
// Rev    : 1.0
// ============================================================================
module sub_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : sub_1bit
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module : serial_sub
// Brief  : Bit-serial LSB-first subtractor with valid/ready handshakes.
//          Optional signed overflow flag with SERIAL_SUB_OVERFLOW_EN.
// Rev    : 1.0
// ============================================================================
module serial_sub
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int             CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  c_LAST = CW'(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_sh_next;

  sub_1bit u_sub_1bit (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bo)
  );

  // New bit enters at the MSB so the word is LSB-aligned after WIDTH steps.
  generate
    if (WIDTH == 1) begin : g_sh_w1
      assign w_sh_next = w_d;
    end else begin : g_sh_wn
      assign w_sh_next = {w_d, r_sh[WIDTH-1:1]};
    end
  endgenerate

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_diff  <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          // One extra RUN cycle after the last bit publishes the result.
          if (r_cnt == c_LAST) begin
            r_diff  <= r_sh;
            r_bout  <= r_br;
            r_state <= DONE;
          end else begin
            r_sh  <= w_sh_next;
            r_br  <= w_bo;
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic r_sa;
  logic r_sb;
  logic r_ovf;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_sa <= a[WIDTH-1];
        r_sb <= b[WIDTH-1];
      end
      if (r_state == RUN && r_cnt == c_LAST) begin
        r_ovf <= (r_sa != r_sb) && (r_sh[WIDTH-1] != r_sa);
      end
    end
  end

  assign overflow = r_ovf;
`endif

endmodule : serial_sub
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module : tb_serial_sub
// Brief  : Self-checking bench for serial_sub (WIDTH=8), vector table + scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_serial_sub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    exp_t         e;
  } vec_t;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         overflow;
`endif

  int   tests;
  int   fails;
  exp_t sbq[$];
  vec_t vecs[10];

  serial_sub #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Arithmetic reference: a wide subtract, borrow is the extra top bit.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    exp_t        r;
    logic [W:0]  t;
    t    = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    r.d  = t[W-1:0];
    r.bo = t[W];
    r.ov = (ma[W-1] != mb[W-1]) && (t[W-1] != ma[W-1]);
    return r;
  endfunction

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input exp_t e, input int hold, input bit pulse);
    int           k;
    exp_t         x;
    logic [W-1:0] dsave;
    logic         bsave;
    k = 0;
    while (!in_ready && k < 40) begin
      @(posedge clock); #1;
      k++;
    end
    check("in_ready_before_accept", in_ready, 1);
    a = ia; b = ib; bin = ibin; in_valid = 1'b1;
    sbq.push_back(e);
    @(posedge clock); #1;
    in_valid = 1'b0;
    a = ~ia; b = ~ib; bin = ~ibin;
    check("in_ready_in_run", in_ready, 0);
    for (k = 1; k <= 40; k++) begin
      if (pulse && k == 3) begin
        in_valid = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b0;
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      if (out_valid) break;
    end
    check("latency_edges", k, W + 1);
    dsave = diff;
    bsave = bout;
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_diff", diff, dsave);
      check("hold_bout", bout, bsave);
      check("hold_in_ready", in_ready, 0);
    end
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    x = sbq.pop_front();
    check("diff", diff, x.d);
    check("bout", bout, x.bo);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("overflow", overflow, x.ov);
`endif
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("out_valid_after_xfer", out_valid, 0);
    check("in_ready_after_xfer", in_ready, 1);
    check("diff_retained", diff, x.d);
    check("bout_retained", bout, x.bo);
  endtask

  initial begin
    exp_t         er;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;
    tests = 0;
    fails = 0;

    vecs[0] = '{8'h05, 8'h03, 1'b0, '{8'h02, 1'b0, 1'b0}};
    vecs[1] = '{8'h03, 8'h05, 1'b0, '{8'hFE, 1'b1, 1'b0}};
    vecs[2] = '{8'h00, 8'h00, 1'b1, '{8'hFF, 1'b1, 1'b0}};
    vecs[3] = '{8'h80, 8'h01, 1'b0, '{8'h7F, 1'b0, 1'b1}};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, '{8'hFF, 1'b1, 1'b0}};
    vecs[5] = '{8'hFF, 8'h00, 1'b0, '{8'hFF, 1'b0, 1'b0}};
    vecs[6] = '{8'h00, 8'hFF, 1'b0, '{8'h01, 1'b1, 1'b0}};
    vecs[7] = '{8'h7F, 8'hFF, 1'b0, '{8'h80, 1'b1, 1'b1}};
    vecs[8] = '{8'h10, 8'h10, 1'b1, '{8'hFF, 1'b1, 1'b0}};
    vecs[9] = '{8'hAA, 8'h55, 1'b1, '{8'h54, 1'b0, 1'b1}};

    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("rst_overflow", overflow, 0);
`endif
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;

    // Vector 0 also exercises DONE back-pressure and an in_valid pulse in RUN.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].e, (i == 0) ? 3 : 0, (i == 0 || i == 3));
    end

    for (int i = 0; i < 6; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      er   = model(ra, rb, rbin);
      run_op(ra, rb, rbin, er, i % 3, 1'b0);
    end

    // Abort an operation mid-RUN with a one-cycle reset pulse.
    a = 8'h33; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    @(posedge clock); #1;
    check("abort_out_valid_held", out_valid, 0);
    reset_n = 1'b1;
    er = '{8'h05, 1'b0, 1'b0};
    run_op(8'h09, 8'h04, 1'b0, er, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_sub
`default_nettype wire
